// File: rtl/booth_ctrl.sv
// Sequencer for a radix-2 Booth multiplier datapath: load, examine, add/sub, shift, done.
// Optional feature: define BOOTH_ABORT_EN to add an abort input that cancels an operation.
module booth_ctrl #(
    parameter int unsigned REG_WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(REG_WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef BOOTH_ABORT_EN
    input  logic             abort,
`endif
    input  logic             q0,
    input  logic             qm1,
    output logic             ld_m,
    output logic             ld_q,
    output logic             clr_a,
    output logic             ld_a,
    output logic             alu_sub,
    output logic             shr,
    output logic             dump,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] EXAMINE = 3'd2;
    localparam logic [2:0] SUB     = 3'd3;
    localparam logic [2:0] ADD     = 3'd4;
    localparam logic [2:0] SHIFT   = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                cnt_d   = CNT_W'(REG_WIDTH);
                state_d = EXAMINE;
            end
            EXAMINE: begin
                case ({q0, qm1})
                    2'b10:   state_d = SUB;
                    2'b01:   state_d = ADD;
                    default: state_d = SHIFT;
                endcase
            end
            SUB, ADD: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                // cnt is at least 1 here, so the decrement cannot wrap
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? DONE : EXAMINE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
`ifdef BOOTH_ABORT_EN
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore outputs: decoded from the registered state only
    assign ld_m    = (state_q == LOAD);
    assign ld_q    = (state_q == LOAD);
    assign clr_a   = (state_q == LOAD);
    assign ld_a    = (state_q == SUB) || (state_q == ADD);
    assign alu_sub = (state_q == SUB);
    assign shr     = (state_q == SHIFT);
    assign dump    = (state_q == DONE);
    assign done    = (state_q == DONE);
    assign busy    = (state_q == LOAD) || (state_q == EXAMINE) || (state_q == SUB) ||
                     (state_q == ADD) || (state_q == SHIFT);
    assign cnt     = cnt_q;

endmodule
